// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_ZERO_Q = {DIV_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Start/done handshake and operand/result bundle between operand source and divider.
interface seq_divider_8bit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract, borrow picks subtract result or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0]   t_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] diff_s;

  // Borrow out of the WIDTH+1-bit subtraction means the trial went negative.
  always_comb begin
    diff_s = t_i - {1'b0, d_i};
    if (diff_s[WIDTH] == 1'b0) begin
      r_o     = diff_s;
      q_bit_o = 1'b1;
    end else begin
      r_o     = t_i;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// results held from the done pulse until a new result is produced.
module seq_divider_8bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_divider_8bit_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   t_s;
  logic [WIDTH:0]   step_r_s;
  logic             step_bit_s;
  logic             unused_s;

  assign t_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  // R never exceeds the divisor, so its top bit only matters inside the step.
  assign unused_s = r_q[WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .t_i     (t_s),
    .d_i     (d_q),
    .r_o     (step_r_s),
    .q_bit_o (step_bit_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            r_d     = '0;
            count_d = CNT_W'(WIDTH - 1);
            dbz_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            quotient_d  = DIV_ZERO_Q;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d = step_r_s;
        q_d = {q_q[WIDTH-2:0], step_bit_s};
        if (count_q == '0) begin
          quotient_d  = {q_q[WIDTH-2:0], step_bit_s};
          remainder_d = step_r_s[WIDTH-1:0];
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
